pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined adder/subtractor for the datapath. It splits a WIDTH-bit add into WIDTH/SEG carry-chained segments, one segment per pipeline stage, with a registered carry passed between stages. It supports add, subtract, add-with-carry and subtract-with-carry, and produces carry, overflow, zero and negative flags. A valid/ready handshake lets the ALU issue one operation per cycle and stall under back-pressure.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of SEG.
- SEG, 8: bits summed per pipeline stage; STAGES = WIDTH/SEG (≥1).
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands/op valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD (A+B), 01 SUB (A+~B+1), 10 ADC (A+B+cin), 11 SBC (A+~B+cin).
- cin  input  1  carry-in; used only for ADC/SBC.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  WIDTH  sum bits.
- cout  output  1  carry out of bit WIDTH-1; for SUB/SBC, 1 means no borrow.
- ovf  output  1  signed overflow: a[W-1]==b_eff[W-1] && result[W-1]!=a[W-1].
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].

## Operation
- Acceptance: an op is accepted on a rising edge where in_valid && in_ready.
- Operand prep at accept: b_eff = op[0] ? ~b : b; c0 = op[1] ? cin : op[0].
- Stage s (0..STAGES-1) registers sum bits [s*SEG +: SEG] = a_seg + b_eff_seg + carry_in_s, plus carry_out_s. carry_in_0 = c0; carry_in_s = registered carry_out_{s-1}.
- Unused upper segments of a and b_eff, and already-computed lower result bits, travel with the op through the stage registers.
- The sign bits a[W-1] and b_eff[W-1] are carried to the last stage for ovf.
- Each stage has a valid bit. Empty stages are bubbles and carry don't-care data.
- The pipeline advances as a whole. adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid and out_ready.
- When adv=0, every stage register and valid bit holds. in_valid is ignored, because in_ready=0.
- Bubbles are not compressed. A stalled pipeline with gaps keeps its gaps.
- Output stage: result, cout, ovf, zero and neg are all registered together with out_valid. No combinational path runs from a/b to the outputs.
- Results leave in acceptance order. No op is dropped or duplicated.
- STAGES==1 degenerates to a single registered full-width add with the same handshake.

## Timing
- Reset (clr=1, asynchronous): all stage valid bits 0, out_valid=0, result=0, cout=0, ovf=0, zero=0, neg=0.
- in_ready=1 while clr is deasserted and the pipeline is empty.
- Reset mid-operation discards all in-flight ops. The first edge after clr falls behaves as an empty pipeline.
- Latency: an op accepted at edge k has out_valid=1 after edge k+STAGES, provided adv=1 on every intervening edge. Each cycle of adv=0 adds one cycle of latency.
- Throughput: one op per cycle while out_ready=1.
- out_valid held with out_ready=0: result and flags stay stable; in_ready=0 in the same cycle.
- Simultaneous pop and push (out_valid && out_ready && in_valid): both complete on the same edge with no bubble inserted.
- Wrap-around: result is modulo 2^WIDTH. The carry beyond bit WIDTH-1 appears only on cout.

## Test plan
- ADD, WIDTH=32, SEG=8: a=0x0000_00FF, b=0x0000_0001 -> after 4 cycles result=0x0000_0100, cout=0, ovf=0, zero=0, neg=0. Checks the inter-stage carry.
- Full carry ripple: ADD a=0xFFFF_FFFF, b=0x0000_0001 -> result=0, cout=1, zero=1, ovf=0.
- SUB a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, cout=1, ovf=1, neg=0. SBC a=5, b=5, cin=0 -> result=0xFFFF_FFFF, cout=0, neg=1.
- Back-to-back stream of 10 ADDs with out_ready=1 -> 10 consecutive out_valid cycles in order, starting 4 cycles after the first accept. Then set out_ready=0 for 3 cycles mid-stream -> in_ready=0 and outputs frozen for those 3 cycles, with no loss and no duplication.
- Assert clr with 3 ops in flight -> out_valid=0 and all outputs 0 immediately. No stale results appear after release.
- Randomised ops/operands/cin and random out_ready for WIDTH=16/SEG=4 and WIDTH=32/SEG=32, compared against a reference model -> all fields match in order.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined add/sub/adc/sbc, one SEG-bit carry segment per stage; results appear WIDTH/SEG cycles after accept.
// The whole pipe stalls while out_valid && !out_ready, so in_ready = !out_valid || out_ready.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / SEG;

  // a/b travel whole so their sign bits reach the last stage; r collects finished segments
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             c;
  } stage_t;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam logic [WIDTH-1:0] SEGMSK = WIDTH'({SEG{1'b1}}) << (s * SEG);

    stage_t           q;
    logic             v;
    logic [SEG:0]     sum;
    logic [WIDTH-1:0] sum_r;

    assign sum   = {1'b0, SEG'(q.a >> (s * SEG))} + {1'b0, SEG'(q.b >> (s * SEG))}
                 + {{SEG{1'b0}}, q.c};
    assign sum_r = (q.r & ~SEGMSK) | (WIDTH'(sum[SEG-1:0]) << (s * SEG));

    if (s == 0) begin : g_in
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          q <= '0;
          v <= 1'b0;
        end else if (adv) begin
          v   <= in_valid;
          q.a <= a;
          q.b <= op[0] ? ~b : b;
          q.r <= '0;
          q.c <= op[1] ? cin : op[0];
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          q <= '0;
          v <= 1'b0;
        end else if (adv) begin
          v <= g_stage[s-1].v;
          q <= {g_stage[s-1].q.a, g_stage[s-1].q.b, g_stage[s-1].sum_r, g_stage[s-1].sum[SEG]};
        end
      end
    end
  end

  logic             fin_v;
  logic [WIDTH-1:0] fin_r;
  logic             fin_c;
  logic             fin_sa;
  logic             fin_sb;

  assign fin_v  = g_stage[STAGES-1].v;
  assign fin_r  = g_stage[STAGES-1].sum_r;
  assign fin_c  = g_stage[STAGES-1].sum[SEG];
  assign fin_sa = g_stage[STAGES-1].q.a[WIDTH-1];
  assign fin_sb = g_stage[STAGES-1].q.b[WIDTH-1];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (adv) begin
      out_valid <= fin_v;
      result    <= fin_r;
      cout      <= fin_c;
      ovf       <= (fin_sa == fin_sb) && (fin_r[WIDTH-1] != fin_sa);
      zero      <= (fin_r == '0);
      neg       <= fin_r[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three geometries (32/8, 16/4, 32/32) share one stimulus stream,
// each with its own in-order scoreboard fed by a whole-word arithmetic reference model.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        cin;

  logic [2:0]  iry;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [2:0]  zf;
  logic [2:0]  nf;
  logic [31:0] r0;
  logic [15:0] r1;
  logic [31:0] r2;

  logic [35:0] got [3];
  logic [35:0] sb  [3][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(32), .SEG(8)) u0 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(iry[0]), .a(a), .b(b), .op(op),
    .cin(cin), .out_valid(ov[0]), .out_ready(out_ready), .result(r0), .cout(co[0]),
    .ovf(of[0]), .zero(zf[0]), .neg(nf[0]));

  pipe_adder #(.WIDTH(16), .SEG(4)) u1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(iry[1]), .a(a[15:0]), .b(b[15:0]),
    .op(op), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready), .result(r1), .cout(co[1]),
    .ovf(of[1]), .zero(zf[1]), .neg(nf[1]));

  pipe_adder #(.WIDTH(32), .SEG(32)) u2 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(iry[2]), .a(a), .b(b), .op(op),
    .cin(cin), .out_valid(ov[2]), .out_ready(out_ready), .result(r2), .cout(co[2]),
    .ovf(of[2]), .zero(zf[2]), .neg(nf[2]));

  assign got[0] = {r0, co[0], of[0], zf[0], nf[0]};
  assign got[1] = {16'h0, r1, co[1], of[1], zf[1], nf[1]};
  assign got[2] = {r2, co[2], of[2], zf[2], nf[2]};

  function automatic int wid(input int i);
    return (i == 1) ? 16 : 32;
  endfunction

  // {result, cout, ovf, zero, neg} for a w-bit adder, from plain wide arithmetic
  function automatic logic [35:0] model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                        input logic [1:0] iop, input logic icin);
    logic [31:0] mask;
    logic [31:0] ae;
    logic [31:0] be;
    logic [31:0] r;
    logic [32:0] full;
    logic        c;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    ae   = ia & mask;
    be   = (iop[0] ? ~ib : ib) & mask;
    c    = iop[1] ? icin : iop[0];
    full = {1'b0, ae} + {1'b0, be} + {32'h0, c};
    r    = full[31:0] & mask;
    return {r, full[w], (ae[w-1] == be[w-1]) && (r[w-1] != ae[w-1]), r == 32'h0, r[w-1]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; handshakes are judged just before the edge, outputs read 1ns after it
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [1:0] iop, input logic icin, input logic ordy);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    cin       = icin;
    out_ready = ordy;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && out_ready) begin
        if (sb[i].size() == 0)
          chk($sformatf("spurious_vld_u%0d", i), 64'(ov[i]), 64'd0);
        else
          chk($sformatf("sb_u%0d", i), 64'(got[i]), 64'(sb[i].pop_front()));
      end
      if (in_valid && iry[i])
        sb[i].push_back(model(wid(i), a, b, op, cin));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [1:0] iop, input logic icin, input logic [35:0] exp);
    step(1'b1, ia, ib, iop, icin, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, $urandom, $urandom, 2'(i), 1'b0, 1'b1);
      chk($sformatf("%s_vld32_%0d", tag, i), 64'(ov[0]), 64'(i == 4));
      chk($sformatf("%s_vld16_%0d", tag, i), 64'(ov[1]), 64'(i == 4));
      if (i == 1)
        chk($sformatf("%s_vld1stage", tag), 64'(ov[2]), 64'd1);
    end
    chk($sformatf("%s_val", tag), 64'(got[0]), 64'(exp));
  endtask

  initial begin
    clr       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = 2'b00;
    cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_vld_u%0d", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst_out_u%0d", i), 64'(got[i]), 64'd0);
    end
    clr = 1'b0;
    #1;
    chk("idle_rdy", 64'(iry[0]), 64'd1);

    // directed single ops through an empty pipe
    run_one("add_carry",  32'h0000_00FF, 32'h0000_0001, 2'b00, 1'b0, {32'h0000_0100, 4'b0000});
    run_one("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, {32'h0000_0000, 4'b1010});
    run_one("sub_ovf",    32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, {32'h7FFF_FFFF, 4'b1100});
    run_one("sbc_borrow", 32'h0000_0005, 32'h0000_0005, 2'b11, 1'b0, {32'hFFFF_FFFF, 4'b0001});
    run_one("adc_ovf",    32'h7FFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, {32'h8000_0000, 4'b0101});

    // back-to-back stream of 10 ADDs
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h0100_0000 * i + 32'(i), 32'h0011_0011 * i, 2'b00, 1'b0, 1'b1);
      chk($sformatf("stream_vld%0d", i), 64'(ov[0]), 64'(i >= 4));
    end
    for (int j = 0; j < 5; j++) begin
      step(1'b0, $urandom, $urandom, 2'b00, 1'b0, 1'b1);
      chk($sformatf("stream_drain%0d", j), 64'(ov[0]), 64'(j < 4));
    end
    chk("stream_count", 64'(sb[0].size()), 64'd0);

    // three-cycle stall mid-stream
    for (int i = 0; i < 6; i++)
      step(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      chk($sformatf("stall_rdy%0d", i), 64'(iry[0]), 64'd0);
      chk($sformatf("stall_vld%0d", i), 64'(ov[0]), 64'd1);
      chk($sformatf("stall_hold%0d", i), 64'(got[0]), 64'(sb[0][0]));
    end
    for (int i = 0; i < 4; i++)
      step(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b0, $urandom, $urandom, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("stall_noloss_u%0d", i), 64'(sb[i].size()), 64'd0);

    // reset with ops in flight
    for (int i = 0; i < 5; i++)
      step(1'b1, $urandom, $urandom, 2'b00, 1'b0, 1'b1);
    #1;
    in_valid = 1'b0;
    clr      = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_vld_u%0d", i), 64'(ov[i]), 64'd0);
      chk($sformatf("midrst_out_u%0d", i), 64'(got[i]), 64'd0);
      sb[i].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step(1'b0, $urandom, $urandom, 2'b00, 1'b0, 1'b1);
      chk($sformatf("postrst_vld%0d", j), 64'(ov[0]), 64'd0);
    end
    run_one("post_rst", 32'h0000_0003, 32'h0000_0004, 2'b00, 1'b0, {32'h0000_0007, 4'b0000});

    // randomised traffic with random back-pressure
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      case ($urandom_range(0, 7))
        0:       ra = 32'hFFFF_FFFF;
        1:       ra = 32'h8000_0000;
        2:       ra = 32'h0000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'hFFFF_FFFF;
        1:       rb = 32'h7FFF_FFFF;
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, ra, rb, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 8; i++)
      step(1'b0, $urandom, $urandom, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rand_drain_u%0d", i), 64'(sb[i].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
